helm_msg_rx: RTL

- Deframes the HELM command byte stream from the UART receiver into message fields, writes the message body into the control stage's message buffer, and issues a one-cycle execute strobe with a checksum verdict.
- Sits between the UART byte receiver and the HELM control FSM.
- Frame format: SYNC, TYPE, PAGE, OFFSET, BODY[0..n-1], CHK.
- CHK is chosen so that the 8-bit sum of TYPE..CHK equals 0x00.

---
 rtl/helm_pkg.sv | 36 +++
 rtl/helm_msg_rx_if.sv | 33 +++
 rtl/helm_rx_timeout.sv | 28 ++
 rtl/helm_msg_rx.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/helm_pkg.sv
// rtl/helm_pkg.sv - HELM message constants and helpers shared with the control stage
package helm_pkg;

    localparam logic [7:0] C_SYNC           = 8'hA5;
    localparam logic [7:0] C_MSG_BLK_WRITE  = 8'h00;
    localparam logic [7:0] C_MSG_BYTE_WRITE = 8'h01;
    localparam logic [7:0] C_MSG_BLK_READ   = 8'h02;
    localparam logic [7:0] C_MAX_LEN        = 8'd253;

    localparam int          C_TO_W    = 16;
    localparam logic [15:0] C_TIMEOUT = 16'd50000;

    // Body buffer addresses 0 and 1 are reserved for the control stage.
    localparam logic [7:0] C_BODY_ADR0 = 8'd2;

    typedef struct packed {
        logic [7:0] msg_type;
        logic [7:0] page;
        logic [7:0] offset;
    } msg_hdr_t;

    // Block write reports 1 here: only the LEN byte is known before it arrives.
    function automatic logic [7:0] body_len(input logic [7:0] msg_type);
        case (msg_type)
            C_MSG_BYTE_WRITE: body_len = 8'd2;
            C_MSG_BLK_READ:   body_len = 8'd1;
            C_MSG_BLK_WRITE:  body_len = 8'd1;
            default:          body_len = 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/helm_msg_rx_if.sv
// rtl/helm_msg_rx_if.sv - byte stream in, deframed message and buffer writes out
interface helm_msg_rx_if;
    import helm_pkg::*;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;

    logic [7:0] msg_type;
    logic [7:0] msg_page;
    logic [7:0] msg_offset;
    logic       msg_exec;
    logic       msg_chksum_err;
    logic       msg_data_wr;
    logic [7:0] msg_data_adr;
    logic [7:0] msg_data;
    logic       busy;
    logic       frame_abort;
    logic [7:0] err_cnt;

    modport master (
        output rx_valid, rx_data, rx_err,
        input  msg_type, msg_page, msg_offset, msg_exec, msg_chksum_err,
        input  msg_data_wr, msg_data_adr, msg_data, busy, frame_abort, err_cnt
    );

    modport slave (
        input  rx_valid, rx_data, rx_err,
        output msg_type, msg_page, msg_offset, msg_exec, msg_chksum_err,
        output msg_data_wr, msg_data_adr, msg_data, busy, frame_abort, err_cnt
    );

endinterface

// File: rtl/helm_rx_timeout.sv
// rtl/helm_rx_timeout.sv - clearable saturating up-counter with terminal-count strobe
module helm_rx_timeout #(
    parameter int           W     = 16,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A byte arriving on the terminal cycle restarts the count instead of expiring.
    assign tc = en && !clr && (cnt == LIMIT);

endmodule

// File: rtl/helm_msg_rx.sv
// rtl/helm_msg_rx.sv - HELM frame deframer: header latch, body buffer writes, checksum verdict
module helm_msg_rx
    import helm_pkg::*;
(
    input  logic           clk,
    input  logic           rst_b,
    helm_msg_rx_if.slave   bus
);

    localparam logic [2:0] S_HUNT = 3'd0;
    localparam logic [2:0] S_TYPE = 3'd1;
    localparam logic [2:0] S_PAGE = 3'd2;
    localparam logic [2:0] S_OFFS = 3'd3;
    localparam logic [2:0] S_BODY = 3'd4;
    localparam logic [2:0] S_CHK  = 3'd5;
    localparam logic [2:0] S_EXEC = 3'd6;

    logic [2:0] state;
    msg_hdr_t   hdr;
    logic [7:0] sum;
    logic [7:0] rem;
    logic       len_phase;
    logic [7:0] adr;
    logic       chksum_err;
    logic       data_wr;
    logic [7:0] data_adr;
    logic [7:0] data;
    logic       abort_q;
    logic [7:0] err_cnt;

    logic       busy;
    logic       to_tc;
    logic       bad_len;
    logic       abort_now;
    logic [7:0] sum_next;
    logic [7:0] offs_len;

    assign busy = (state != S_HUNT);

    helm_rx_timeout #(
        .W     (C_TO_W),
        .LIMIT (C_TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (bus.rx_valid || !busy),
        .en    (busy),
        .tc    (to_tc)
    );

    always_comb begin
        sum_next  = sum + bus.rx_data;
        offs_len  = body_len(hdr.msg_type);
        bad_len   = (state == S_BODY) && bus.rx_valid && len_phase && (bus.rx_data > C_MAX_LEN);
        // EXEC is already committed, so nothing can abort it.
        abort_now = busy && (state != S_EXEC) && (bus.rx_err || to_tc || bad_len);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= S_HUNT;
            hdr        <= '0;
            sum        <= '0;
            rem        <= '0;
            len_phase  <= 1'b0;
            adr        <= '0;
            chksum_err <= 1'b0;
            data_wr    <= 1'b0;
            data_adr   <= '0;
            data       <= '0;
            abort_q    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            data_wr <= 1'b0;
            abort_q <= 1'b0;
            if (abort_now) begin
                abort_q <= 1'b1;
                err_cnt <= sat_inc(err_cnt);
                state   <= S_HUNT;
            end else begin
                case (state)
                    S_HUNT: begin
                        if (bus.rx_valid && bus.rx_data == C_SYNC) begin
                            state <= S_TYPE;
                        end
                    end
                    S_TYPE: begin
                        if (bus.rx_valid) begin
                            hdr.msg_type <= bus.rx_data;
                            sum          <= bus.rx_data;
                            state        <= S_PAGE;
                        end
                    end
                    S_PAGE: begin
                        if (bus.rx_valid) begin
                            hdr.page <= bus.rx_data;
                            sum      <= sum_next;
                            state    <= S_OFFS;
                        end
                    end
                    S_OFFS: begin
                        if (bus.rx_valid) begin
                            hdr.offset <= bus.rx_data;
                            sum        <= sum_next;
                            rem        <= offs_len;
                            len_phase  <= (hdr.msg_type == C_MSG_BLK_WRITE);
                            adr        <= C_BODY_ADR0;
                            state      <= (offs_len == 8'd0) ? S_CHK : S_BODY;
                        end
                    end
                    S_BODY: begin
                        if (bus.rx_valid) begin
                            sum      <= sum_next;
                            data_wr  <= 1'b1;
                            data_adr <= adr;
                            data     <= bus.rx_data;
                            adr      <= adr + 8'd1;
                            if (len_phase) begin
                                // LEN counts only the data bytes that follow it.
                                len_phase <= 1'b0;
                                rem       <= bus.rx_data;
                                if (bus.rx_data == 8'd0) begin
                                    state <= S_CHK;
                                end
                            end else begin
                                rem <= rem - 8'd1;
                                if (rem == 8'd1) begin
                                    state <= S_CHK;
                                end
                            end
                        end
                    end
                    S_CHK: begin
                        if (bus.rx_valid) begin
                            sum        <= sum_next;
                            chksum_err <= (sum_next != 8'd0);
                            if (sum_next != 8'd0) begin
                                err_cnt <= sat_inc(err_cnt);
                            end
                            state <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        state <= S_HUNT;
                    end
                    default: begin
                        state <= S_HUNT;
                    end
                endcase
            end
        end
    end

    assign bus.msg_type       = hdr.msg_type;
    assign bus.msg_page       = hdr.page;
    assign bus.msg_offset     = hdr.offset;
    assign bus.msg_exec       = (state == S_EXEC);
    assign bus.msg_chksum_err = chksum_err;
    assign bus.msg_data_wr    = data_wr;
    assign bus.msg_data_adr   = data_adr;
    assign bus.msg_data       = data;
    assign bus.busy           = busy;
    assign bus.frame_abort    = abort_q;
    assign bus.err_cnt        = err_cnt;

endmodule
